// File: rtl/seq_check_pkg.sv
// rtl/seq_check_pkg.sv - shared state encoding and length helpers for seq_check_param
package seq_check_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    // Lengths outside 1..max_len are pulled to the nearest legal value.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

    // Low len bits set; callers truncate to their pattern width (max 31 bits).
    function automatic logic [31:0] len_mask(input int unsigned len);
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// rtl/seq_hist_shift.sv - serial history shift register with saturating fill count
module seq_hist_shift #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               data,
    input  logic               data_vld,
    output logic [MAX_LEN-1:0] hist,
    output logic [LEN_W-1:0]   fill
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (data_vld) begin
            hist <= {hist[MAX_LEN-2:0], data};
            if (fill != LEN_W'(MAX_LEN))
                fill <= fill + LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_check_param.sv
// rtl/seq_check_param.sv - programmable serial pattern detector; SEQ_CNT_EN adds a saturating match counter
module seq_check_param
    import seq_check_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data,
    input  logic               data_vld,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               clr_cnt,
    output logic               ind,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic               ovl_q;
    state_t             state_q;
    state_t             state_d;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               match;
    logic               match_eff;
    logic               clr_hist;
    logic               unused_hist_msb;

    assign len_d  = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
    assign mask   = MAX_LEN'(len_mask(32'(len_q)));
    assign window = {hist[MAX_LEN-2:0], data};

    // Oldest history bit only ever feeds the shift chain, never the compare.
    assign unused_hist_msb = hist[MAX_LEN-1];

    assign match     = (state_q == S_ARMED) && data_vld && (((window ^ pat_q) & mask) == '0);
    assign match_eff = match && !cfg_we;
    assign clr_hist  = cfg_we || (match && !ovl_q);
    assign armed     = (state_q == S_ARMED);

    seq_hist_shift #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_hist),
        .data     (data),
        .data_vld (data_vld),
        .hist     (hist),
        .fill     (fill)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= '0;
            len_q   <= LEN_W'(1);
            ovl_q   <= 1'b0;
            state_q <= S_IDLE;
            ind     <= 1'b0;
        end else begin
            if (cfg_we) begin
                pat_q <= cfg_pat;
                len_q <= len_d;
                ovl_q <= cfg_ovl;
            end
            state_q <= state_d;
            ind     <= match_eff;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            // fill is zero on entry, so arm when this bit brings it to len-1
            S_FILL:  if (data_vld && ((fill + LEN_W'(1)) >= (len_q - LEN_W'(1))))
                         state_d = S_ARMED;
            S_ARMED: if (match && !ovl_q && (len_q != LEN_W'(1)))
                         state_d = S_FILL;
            default: state_d = S_IDLE;
        endcase
        if (cfg_we)
            state_d = (len_d == LEN_W'(1)) ? S_ARMED : S_FILL;
    end

`ifdef SEQ_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr_cnt)
            cnt_q <= '0;
        else if (match_eff && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign match_cnt = cnt_q;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign match_cnt      = '0;
`endif

endmodule
